// File: rtl/replica_pkg.sv
// Shared types for the replica-exchange node: index/distance
// types, pairing modes, FSM states and LFSR feedback taps.
package replica_pkg;

  localparam int DIS_W_DEF   = 32;
  localparam int REP_LOG_DEF = 3;

  typedef logic [DIS_W_DEF-1:0]   rep_total_t;
  typedef logic [REP_LOG_DEF-1:0] rep_idx_t;

  typedef enum logic [1:0] {
    PAIR_EVEN = 2'd0,
    PAIR_ODD  = 2'd1,
    PAIR_ALT  = 2'd2
  } pair_mode_t;

  typedef enum logic [1:0] {
    EX_IDLE  = 2'd0,
    EX_TEST  = 2'd1,
    EX_ISSUE = 2'd2,
    EX_DONE  = 2'd3
  } ex_state_t;

  // x^16+x^14+x^13+x^11, right-shifting form:
  // feedback from bits 0,2,3,5 into bit 15
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/ex_lfsr.sv
// Right-shifting Fibonacci LFSR used as the exchange random source.
// Ports: clk, reset (async high), adv (step enable), value (state).
module ex_lfsr
  import replica_pkg::*;
#(
  parameter int               RND_W = 16,
  parameter logic [RND_W-1:0] SEED  = 16'hACE1,
  parameter logic [RND_W-1:0] TAPS  = LFSR_TAPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [RND_W-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (adv) begin
      value <= {^(value & TAPS), value[RND_W-1:1]};
    end
  end

endmodule

// File: rtl/replica_exchange_node.sv
// Per-node replica exchange: holds REP_NUM distances, tests adjacent
// pairs of one parity per round, swaps accepted pairs and issues a
// swap command per accept over valid/ready.
// Ports: dis_*/thr_* writes, shift_* host scan, start/mode/busy/done
// round control, ex_valid/ex_idx/ex_ready swap command, swap_cnt.
module replica_exchange_node
  import replica_pkg::*;
#(
  parameter int               REP_NUM = 8,
  parameter int               REP_LOG = 3,
  parameter int               DIS_W   = 32,
  parameter int               RND_W   = 16,
  parameter logic [RND_W-1:0] SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dis_we,
  input  logic [REP_LOG-1:0] dis_widx,
  input  logic [DIS_W-1:0]   dis_wdata,
  input  logic               thr_we,
  input  logic [REP_LOG-1:0] thr_widx,
  input  logic [DIS_W-1:0]   thr_wdata,
  input  logic               shift_en,
  input  logic [DIS_W-1:0]   shift_in,
  output logic [DIS_W-1:0]   shift_out,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic               ex_valid,
  output logic [REP_LOG-1:0] ex_idx,
  input  logic               ex_ready,
  output logic [15:0]        swap_cnt
);

  localparam int PW = DIS_W + RND_W;

  logic [DIS_W-1:0]   d   [REP_NUM];
  logic [DIS_W-1:0]   thr [REP_NUM];

  ex_state_t          state;
  pair_mode_t         mode_r;
  pair_mode_t         mode_n;
  logic               alt;
  logic [REP_LOG-1:0] idx;
  logic [REP_LOG-1:0] idx_hi;
  logic [RND_W-1:0]   rnd;

  logic               par;
  logic               par_last;
  logic [REP_LOG:0]   nxt;
  logic               nxt_last;
  logic [DIS_W:0]     diff;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      lim;
  logic               accept;
  logic               in_idle;

  ex_lfsr #(
    .RND_W (RND_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (state == EX_TEST),
    .value (rnd)
  );

  // Reserved mode 3 behaves as even pairing.
  always_comb begin
    mode_n = PAIR_EVEN;
    case (mode)
      2'd1:    mode_n = PAIR_ODD;
      2'd2:    mode_n = PAIR_ALT;
      default: mode_n = PAIR_EVEN;
    endcase
  end

  always_comb begin
    par = 1'b0;
    if (mode_n == PAIR_ODD) par = 1'b1;
    if (mode_n == PAIR_ALT) par = alt;
  end

  assign par_last = (int'(par) + 1) >= REP_NUM;

  assign idx_hi   = idx + REP_LOG'(1);
  assign nxt      = {1'b0, idx} + (REP_LOG + 1)'(2);
  assign nxt_last = (int'(nxt) + 1) >= REP_NUM;

  // Unsigned operands widened by one bit so the sign bit
  // of diff tells whether the upper replica is shorter.
  assign diff = {1'b0, d[idx_hi]} - {1'b0, d[idx]};
  assign prod = {{RND_W{1'b0}}, thr[idx]} * {{DIS_W{1'b0}}, rnd};
  assign lim  = prod >> RND_W;

  assign accept = diff[DIS_W]
               || (diff == '0)
               || ({{RND_W{1'b0}}, diff[DIS_W-1:0]} < lim);

  assign in_idle   = (state == EX_IDLE);
  assign busy      = !in_idle;
  assign done      = (state == EX_DONE);
  assign ex_valid  = (state == EX_ISSUE);
  assign ex_idx    = idx;
  assign shift_out = d[REP_NUM-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EX_IDLE;
      mode_r   <= PAIR_EVEN;
      alt      <= 1'b0;
      idx      <= '0;
      swap_cnt <= '0;
    end else begin
      unique case (state)
        EX_IDLE: begin
          if (start) begin
            mode_r <= mode_n;
            idx    <= {{(REP_LOG-1){1'b0}}, par};
            state  <= par_last ? EX_DONE : EX_TEST;
          end
        end
        EX_TEST: begin
          if (accept) begin
            if (swap_cnt != 16'hFFFF) swap_cnt <= swap_cnt + 16'd1;
            state <= EX_ISSUE;
          end else begin
            idx   <= nxt[REP_LOG-1:0];
            state <= nxt_last ? EX_DONE : EX_TEST;
          end
        end
        EX_ISSUE: begin
          if (ex_ready) begin
            idx   <= nxt[REP_LOG-1:0];
            state <= nxt_last ? EX_DONE : EX_TEST;
          end
        end
        EX_DONE: begin
          if (mode_r == PAIR_ALT) alt <= ~alt;
          state <= EX_IDLE;
        end
      endcase
    end
  end

  // Host access only while idle; the swap of an accepted
  // pair lands on the same edge that leaves TEST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < REP_NUM; k++) begin
        d[k]   <= '0;
        thr[k] <= '0;
      end
    end else if (in_idle) begin
      if (shift_en) begin
        d[0] <= shift_in;
        for (int k = 1; k < REP_NUM; k++) d[k] <= d[k-1];
      end else if (dis_we && (int'(dis_widx) < REP_NUM)) begin
        d[dis_widx] <= dis_wdata;
      end
      if (thr_we && (int'(thr_widx) < REP_NUM)) begin
        thr[thr_widx] <= thr_wdata;
      end
    end else if ((state == EX_TEST) && accept) begin
      d[idx]    <= d[idx_hi];
      d[idx_hi] <= d[idx];
    end
  end

endmodule

// File: tb/tb_replica_exchange_node.sv
// Self-checking bench for replica_exchange_node: directed vector
// table, stall/reset sequences and a reference-model random run.
module tb_replica_exchange_node;

  localparam int N = 8;

  typedef logic [N-1:0][31:0] dvec_t;

  typedef struct {
    logic [1:0] m;
    dvec_t      din;
    logic [7:0] mask;
    int         cyc;
    dvec_t      dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dis_we;
  logic [2:0]  dis_widx;
  logic [31:0] dis_wdata;
  logic        thr_we;
  logic [2:0]  thr_widx;
  logic [31:0] thr_wdata;
  logic        shift_en;
  logic [31:0] shift_in;
  logic [31:0] shift_out;
  logic        start;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic        ex_valid;
  logic [2:0]  ex_idx;
  logic        ex_ready;
  logic [15:0] swap_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  replica_exchange_node dut (
    .clk       (clk),
    .reset     (reset),
    .dis_we    (dis_we),
    .dis_widx  (dis_widx),
    .dis_wdata (dis_wdata),
    .thr_we    (thr_we),
    .thr_widx  (thr_widx),
    .thr_wdata (thr_wdata),
    .shift_en  (shift_en),
    .shift_in  (shift_in),
    .shift_out (shift_out),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .ex_valid  (ex_valid),
    .ex_idx    (ex_idx),
    .ex_ready  (ex_ready),
    .swap_cnt  (swap_cnt)
  );

  function automatic dvec_t dv(
    input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7
  );
    dvec_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        nm,
    input logic [255:0] act,
    input logic [255:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input dvec_t dvv, input dvec_t tvv, input bit wthr);
    for (int k = 0; k < N; k++) begin
      dis_we    = 1'b1;
      dis_widx  = 3'(k);
      dis_wdata = dvv[k];
      thr_we    = wthr;
      thr_widx  = 3'(k);
      thr_wdata = tvv[k];
      tick();
    end
    dis_we = 1'b0;
    thr_we = 1'b0;
  endtask

  // Scan out d[7]..d[0]; zeros are shifted in behind.
  task automatic scan(output dvec_t v);
    shift_en = 1'b1;
    shift_in = '0;
    for (int k = N - 1; k >= 0; k--) begin
      v[k] = shift_out;
      tick();
    end
    shift_en = 1'b0;
  endtask

  task automatic run_round(
    input  logic [1:0] m,
    input  bit         rnd,
    output logic [7:0] mask,
    output int         cyc
  );
    mode     = m;
    ex_ready = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    mask  = '0;
    chk("busy_after_start", busy, 1);
    while (!done && cyc < 300) begin
      if (rnd) ex_ready = 1'($urandom_range(0, 1));
      if (ex_valid && ex_ready) mask[ex_idx] = 1'b1;
      tick();
      cyc++;
    end
    chk("done_seen", done, 1);
    tick();
    chk("done_one_cycle", {busy, done}, 0);
    ex_ready = 1'b1;
  endtask

  vec_t        tbl [10];
  dvec_t       zero_v;
  dvec_t       got;
  dvec_t       md;
  dvec_t       mt;
  logic [7:0]  mask;
  logic [7:0]  mmask;
  logic [15:0] ml;
  logic        malt;
  logic        fb;
  int          cyc;
  int          exp_cnt;
  int          w;
  int          p;
  int          diff;
  longint      lim;
  logic [1:0]  m;
  logic [31:0] tmp;

  initial begin
    zero_v = '0;

    tbl[0] = '{2'd0, dv(10, 9, 8, 7, 6, 5, 4, 3), 8'h55, 9,
               dv(9, 10, 7, 8, 5, 6, 3, 4)};
    tbl[1] = '{2'd1, dv(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 4,
               dv(1, 2, 3, 4, 5, 6, 7, 8)};
    tbl[2] = '{2'd3, dv(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 5,
               dv(1, 2, 3, 4, 5, 6, 7, 8)};
    tbl[3] = '{2'd1, dv(8, 7, 6, 5, 4, 3, 2, 1), 8'h2A, 7,
               dv(8, 6, 7, 4, 5, 2, 3, 1)};
    tbl[4] = '{2'd0, dv(5, 5, 5, 5, 5, 5, 5, 5), 8'h55, 9,
               dv(5, 5, 5, 5, 5, 5, 5, 5)};
    tbl[5] = '{2'd0, dv(1, 2, 5, 3, 7, 7, 0, 9), 8'h14, 7,
               dv(1, 2, 3, 5, 7, 7, 0, 9)};
    tbl[6] = '{2'd0,
               dv(32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 5, 5, 7, 6),
               8'h51, 8,
               dv(0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 5, 5, 6, 7)};
    tbl[7] = '{2'd2, dv(8, 7, 6, 5, 4, 3, 2, 1), 8'h55, 9,
               dv(7, 8, 5, 6, 3, 4, 1, 2)};
    tbl[8] = '{2'd2, dv(8, 7, 6, 5, 4, 3, 2, 1), 8'h2A, 7,
               dv(8, 6, 7, 4, 5, 2, 3, 1)};
    tbl[9] = '{2'd2, dv(8, 7, 6, 5, 4, 3, 2, 1), 8'h55, 9,
               dv(7, 8, 5, 6, 3, 4, 1, 2)};

    reset     = 1'b1;
    dis_we    = 1'b0;
    dis_widx  = '0;
    dis_wdata = '0;
    thr_we    = 1'b0;
    thr_widx  = '0;
    thr_wdata = '0;
    shift_en  = 1'b0;
    shift_in  = '0;
    start     = 1'b0;
    mode      = '0;
    ex_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_idx", ex_idx, 0);
    chk("rst_swap_cnt", swap_cnt, 0);
    chk("rst_shift_out", shift_out, 0);

    exp_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      load(tbl[t].din, zero_v, 1'b0);
      run_round(tbl[t].m, 1'b0, mask, cyc);
      exp_cnt += $countones(tbl[t].mask);
      chk($sformatf("v%0d_mask", t), mask, tbl[t].mask);
      chk($sformatf("v%0d_cycles", t), cyc, tbl[t].cyc);
      chk($sformatf("v%0d_swap_cnt", t), swap_cnt, exp_cnt);
      scan(got);
      chk($sformatf("v%0d_dist", t), got, tbl[t].dout);
    end

    // Consumer stall: command must hold, host writes ignored.
    load(dv(10, 9, 8, 7, 6, 5, 4, 3), zero_v, 1'b0);
    mode     = 2'd0;
    ex_ready = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!ex_valid && w < 10) begin
      tick();
      w++;
    end
    chk("stall_valid", ex_valid, 1);
    for (int j = 0; j < 5; j++) begin
      chk("stall_valid_hold", ex_valid, 1);
      chk("stall_idx_hold", ex_idx, 0);
      chk("stall_cnt_hold", swap_cnt, exp_cnt + 1);
      dis_we    = 1'b1;
      dis_widx  = 3'd0;
      dis_wdata = 32'd99;
      shift_en  = (j == 2);
      start     = 1'b1;
      tick();
    end
    dis_we   = 1'b0;
    shift_en = 1'b0;
    start    = 1'b0;
    ex_ready = 1'b1;
    w = 0;
    while (!done && w < 50) begin
      tick();
      w++;
    end
    chk("stall_done", done, 1);
    tick();
    exp_cnt += 4;
    chk("stall_swap_cnt", swap_cnt, exp_cnt);
    scan(got);
    chk("stall_dist", got, dv(9, 10, 7, 8, 5, 6, 3, 4));

    // Reset while a command is pending.
    load(dv(10, 9, 8, 7, 6, 5, 4, 3), zero_v, 1'b0);
    mode     = 2'd0;
    ex_ready = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!ex_valid && w < 10) begin
      tick();
      w++;
    end
    chk("mid_rst_issue", ex_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_swap_cnt", swap_cnt, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    ex_ready = 1'b1;
    tick();
    chk("mid_rst_no_done", done, 0);
    scan(got);
    chk("mid_rst_dist", got, zero_v);
    load(dv(10, 9, 8, 7, 6, 5, 4, 3), zero_v, 1'b0);
    run_round(2'd0, 1'b0, mask, cyc);
    chk("restart_mask", mask, 8'h55);
    chk("restart_swap_cnt", swap_cnt, 4);

    // Random rounds against a reference model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    ml      = 16'hACE1;
    malt    = 1'b0;
    exp_cnt = 0;
    for (int r = 0; r < 1000; r++) begin
      for (int k = 0; k < N; k++) begin
        md[k] = $urandom_range(0, 200);
        mt[k] = $urandom_range(0, 400);
      end
      load(md, mt, 1'b1);
      m = 2'($urandom_range(0, 3));
      p = (m == 2'd1) ? 1 : ((m == 2'd2) ? int'(malt) : 0);
      mmask = '0;
      for (int i = p; i + 1 < N; i += 2) begin
        diff = int'(md[i+1]) - int'(md[i]);
        lim  = (longint'(mt[i]) * longint'(ml)) >>> 16;
        fb   = ml[0] ^ ml[2] ^ ml[3] ^ ml[5];
        ml   = {fb, ml[15:1]};
        if (diff <= 0 || longint'(diff) < lim) begin
          tmp      = md[i];
          md[i]    = md[i+1];
          md[i+1]  = tmp;
          mmask[i] = 1'b1;
          exp_cnt++;
        end
      end
      if (m == 2'd2) malt = ~malt;
      run_round(m, 1'b1, mask, cyc);
      chk($sformatf("rnd%0d_mask", r), mask, mmask);
      chk($sformatf("rnd%0d_swap_cnt", r), swap_cnt, exp_cnt);
      scan(got);
      chk($sformatf("rnd%0d_dist", r), got, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
